// File: rtl/vscale_valu_seq.sv
// Multi-cycle vector ALU: accepts one vector op over a valid/ready request port,
// computes LANES_PER_CYCLE lanes per clock, then presents the packed result on a
// valid/ready response port until the consumer takes it.
module vscale_valu_seq #(
  parameter int VEC_LEN         = 29,
  parameter int LANES_PER_CYCLE = 4,
  parameter int LANE_W          = 32,
  localparam int ALU_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ALU_OP_WIDTH-1:0]   req_op,
  input  logic                      req_xvec_mode,
  input  logic [VEC_LEN*LANE_W-1:0] req_in1,
  input  logic [VEC_LEN*LANE_W-1:0] req_in2,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [VEC_LEN*LANE_W-1:0] resp_out,
  output logic                      busy
);

  // ALU op encoding shared with the scalar ALU (codes 2 and 3 are unused)
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SEQ  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SNE  = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = 4'd10;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = 4'd11;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = 4'd12;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SGE  = 4'd13;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = 4'd14;
  localparam logic [ALU_OP_WIDTH-1:0] OP_SGEU = 4'd15;

  // Number of beats for a full-vector op; the counter only ever holds 0..NB-1
  localparam int NB     = (VEC_LEN + LANES_PER_CYCLE - 1) / LANES_PER_CYCLE;
  localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int LIDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ALU_OP_WIDTH-1:0]    r_op;
  logic                       r_mode;
  logic [CNT_W-1:0]           r_cnt;
  logic [VEC_LEN*LANE_W-1:0]  r_in1;
  logic [VEC_LEN*LANE_W-1:0]  r_in2;
  logic                       w_accept;
  logic                       w_last;
  logic [LANE_W-1:0]          w_in1_lane [VEC_LEN];
  logic [LANE_W-1:0]          w_in2_lane [VEC_LEN];
  logic [LANE_W-1:0]          w_res      [LANES_PER_CYCLE];

  // One lane of ALU; shift amount comes from the low five bits of the same lane's b
  function automatic logic [LANE_W-1:0] lane_alu(
    input logic [ALU_OP_WIDTH-1:0] op,
    input logic [LANE_W-1:0]       a,
    input logic [LANE_W-1:0]       b
  );
    logic [4:0] sh;
    sh = b[4:0];
    lane_alu = '0;
    case (op)
      OP_ADD:  lane_alu = a + b;
      OP_SUB:  lane_alu = a - b;
      OP_AND:  lane_alu = a & b;
      OP_OR:   lane_alu = a | b;
      OP_XOR:  lane_alu = a ^ b;
      OP_SLL:  lane_alu = a << sh;
      OP_SRL:  lane_alu = a >> sh;
      OP_SRA:  lane_alu = $signed(a) >>> sh;
      OP_SEQ:  lane_alu = {{(LANE_W-1){1'b0}}, (a == b)};
      OP_SNE:  lane_alu = {{(LANE_W-1){1'b0}}, (a != b)};
      OP_SLT:  lane_alu = {{(LANE_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SGE:  lane_alu = {{(LANE_W-1){1'b0}}, ($signed(a) >= $signed(b))};
      OP_SLTU: lane_alu = {{(LANE_W-1){1'b0}}, (a < b)};
      OP_SGEU: lane_alu = {{(LANE_W-1){1'b0}}, (a >= b)};
      default: lane_alu = '0;
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && req_valid;
  // Scalar mode runs a single beat, so only beat 0 can be the last one
  assign w_last   = r_mode ? (r_cnt == LAST_BEAT) : (r_cnt == '0);

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch the op on accept and advance the beat counter while running
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
      r_in1  <= '0;
      r_in2  <= '0;
    end else if (w_accept) begin
      r_op   <= req_op;
      r_mode <= req_xvec_mode;
      r_cnt  <= '0;
      r_in1  <= req_in1;
      r_in2  <= req_in2;
    end else if (r_state == S_RUN && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Latched operands viewed as lane arrays
  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_unpack
    assign w_in1_lane[gi] = r_in1[gi*LANE_W +: LANE_W];
    assign w_in2_lane[gi] = r_in2[gi*LANE_W +: LANE_W];
  end

  // Per-beat compute slots: slot gi handles lane r_cnt*LPC+gi when it exists
  for (genvar gi = 0; gi < LANES_PER_CYCLE; gi++) begin : g_slot
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    int                w_idx;
    // Select this slot's operands, zero for lanes past the end of the vector
    always_comb begin
      w_a   = '0;
      w_b   = '0;
      w_idx = int'(r_cnt) * LANES_PER_CYCLE + gi;
      if (w_idx < VEC_LEN) begin
        w_a = w_in1_lane[LIDX_W'(w_idx)];
        w_b = w_in2_lane[LIDX_W'(w_idx)];
      end
    end
    assign w_res[gi] = lane_alu(r_op, w_a, w_b);
  end

  // Result lanes: cleared on accept, written during the beat that owns them
  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_out
    localparam int SLOT = gi % LANES_PER_CYCLE;
    localparam int BEAT = gi / LANES_PER_CYCLE;
    localparam bit IS_L0 = (gi == 0);
    logic [LANE_W-1:0] r_lane;
    // Upper lanes stay cleared in scalar mode
    always_ff @(posedge clk) begin
      if (reset || w_accept) begin
        r_lane <= '0;
      end else if (r_state == S_RUN && (r_mode || IS_L0) && r_cnt == CNT_W'(BEAT)) begin
        r_lane <= w_res[SLOT];
      end
    end
    assign resp_out[gi*LANE_W +: LANE_W] = r_lane;
  end

endmodule

// File: tb/tb_vscale_valu_seq.sv
// Directed bench for vscale_valu_seq: main instance with 4 lanes/beat plus
// 1 and 29 lanes/beat instances for the latency sweep.
module tb_vscale_valu_seq;

  localparam int VL = 29;
  localparam int LW = 32;
  localparam int VW = VL * LW;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_UNDEF = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;
  localparam logic [3:0] OP_SLTU = 4'd14;
  localparam logic [3:0] OP_SGEU = 4'd15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, sweep_valid;
  logic          resp_ready, sweep_ready;
  logic [3:0]    req_op;
  logic          req_xvec_mode;
  logic [VW-1:0] req_in1, req_in2;

  logic          m_req_ready, m_resp_valid, m_busy;
  logic [VW-1:0] m_resp_out;
  logic          s1_req_ready, s1_resp_valid, s1_busy;
  logic [VW-1:0] s1_resp_out;
  logic          s29_req_ready, s29_resp_valid, s29_busy;
  logic [VW-1:0] s29_resp_out;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int lat, lat_m, lat_s1, lat_s29;
  logic [31:0] exp_l [VL];
  logic seen;

  always #5 clk = ~clk;

  vscale_valu_seq #(.VEC_LEN(VL), .LANES_PER_CYCLE(4), .LANE_W(LW)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(m_req_ready),
    .req_op(req_op), .req_xvec_mode(req_xvec_mode), .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(m_resp_valid), .resp_ready(resp_ready), .resp_out(m_resp_out), .busy(m_busy));

  vscale_valu_seq #(.VEC_LEN(VL), .LANES_PER_CYCLE(1), .LANE_W(LW)) u_dut_l1 (
    .clk(clk), .reset(reset), .req_valid(sweep_valid), .req_ready(s1_req_ready),
    .req_op(req_op), .req_xvec_mode(req_xvec_mode), .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(s1_resp_valid), .resp_ready(sweep_ready), .resp_out(s1_resp_out), .busy(s1_busy));

  vscale_valu_seq #(.VEC_LEN(VL), .LANES_PER_CYCLE(29), .LANE_W(LW)) u_dut_l29 (
    .clk(clk), .reset(reset), .req_valid(sweep_valid), .req_ready(s29_req_ready),
    .req_op(req_op), .req_xvec_mode(req_xvec_mode), .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(s29_resp_valid), .resp_ready(sweep_ready), .resp_out(s29_resp_out), .busy(s29_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [VW-1:0] v);
    for (int i = 0; i < VL; i++)
      chk($sformatf("%s_lane%0d", tag, i), v[i*LW +: LW], exp_l[i]);
  endtask

  // Issue a request on the main instance and count negedges until resp_valid
  task automatic send(input logic [3:0] op, input logic mode, output int l);
    req_op = op;
    req_xvec_mode = mode;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    l = 1;
    while (!m_resp_valid && l < 60) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic pop(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_pop_valid"}, 32'(m_resp_valid), 32'd0);
  endtask

  task automatic load_add_vectors();
    for (int i = 0; i < VL; i++) begin
      req_in1[i*LW +: LW] = 32'(i);
      req_in2[i*LW +: LW] = 32'hFFFF_FFFF;
      exp_l[i] = 32'(i) - 32'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; sweep_valid = 1'b0;
    resp_ready = 1'b0; sweep_ready = 1'b0;
    req_op = '0; req_xvec_mode = 1'b0;
    req_in1 = '0; req_in2 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(m_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(m_resp_valid), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    for (int i = 0; i < VL; i++) exp_l[i] = '0;
    chk_lanes("rst_out", m_resp_out);
    reset = 1'b0;
    @(negedge clk);

    // T1 ADD across all three lane widths at once
    load_add_vectors();
    req_op = OP_ADD; req_xvec_mode = 1'b1;
    req_valid = 1'b1; sweep_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; sweep_valid = 1'b0;
    chk("t1_busy", 32'(m_busy), 32'd1);
    chk("t1_req_ready_run", 32'(m_req_ready), 32'd0);
    lat_m = 0; lat_s1 = 0; lat_s29 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (m_resp_valid && lat_m == 0) lat_m = c;
      if (s1_resp_valid && lat_s1 == 0) lat_s1 = c;
      if (s29_resp_valid && lat_s29 == 0) lat_s29 = c;
      @(negedge clk);
    end
    chk("t1_lat_lpc4", 32'(lat_m), 32'd9);
    chk("t1_lat_lpc1", 32'(lat_s1), 32'd30);
    chk("t1_lat_lpc29", 32'(lat_s29), 32'd2);
    chk("t1_lane0", m_resp_out[0 +: LW], 32'hFFFF_FFFF);
    chk_lanes("t1_lpc4", m_resp_out);
    chk_lanes("t1_lpc1", s1_resp_out);
    chk_lanes("t1_lpc29", s29_resp_out);
    sweep_ready = 1'b1;
    @(negedge clk);
    sweep_ready = 1'b0;
    chk("sweep_busy_lpc1", 32'(s1_busy), 32'd0);
    chk("sweep_busy_lpc29", 32'(s29_busy), 32'd0);

    // T4 backpressure: main still in DONE holding the T1 result
    req_in1 = '1; req_op = OP_SUB; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_valid_c%0d", c), 32'(m_resp_valid), 32'd1);
      chk($sformatf("t4_req_ready_c%0d", c), 32'(m_req_ready), 32'd0);
      chk($sformatf("t4_lane5_c%0d", c), m_resp_out[5*LW +: LW], 32'd4);
      @(negedge clk);
    end
    req_valid = 1'b0;
    pop("t4");
    chk("t4_idle_req_ready", 32'(m_req_ready), 32'd1);
    chk("t4_idle_busy", 32'(m_busy), 32'd0);
    @(negedge clk);
    chk("t4_still_idle", 32'(m_busy), 32'd0);
    chk_lanes("t4_hold", m_resp_out);

    // T2 SRA with per-lane shift amounts
    for (int i = 0; i < VL; i++) begin
      req_in1[i*LW +: LW] = 32'h8000_0000;
      req_in2[i*LW +: LW] = 32'(i);
      exp_l[i] = 32'hFFFF_FFFF << (31 - i);
    end
    send(OP_SRA, 1'b1, lat);
    chk("t2_lat", 32'(lat), 32'd9);
    chk("t2_lane4_hand", m_resp_out[4*LW +: LW], 32'hF800_0000);
    chk_lanes("t2", m_resp_out);
    pop("t2");

    // T3 SLTU scalar mode: only lane 0 computed, upper lanes cleared
    for (int i = 0; i < VL; i++) begin
      req_in1[i*LW +: LW] = 32'h5555_0000 + 32'(i);
      req_in2[i*LW +: LW] = 32'hAAAA_0000 + 32'(i);
      exp_l[i] = '0;
    end
    req_in1[0 +: LW] = 32'd1;
    req_in2[0 +: LW] = 32'd2;
    exp_l[0] = 32'd1;
    send(OP_SLTU, 1'b0, lat);
    chk("t3_lat", 32'(lat), 32'd2);
    chk_lanes("t3", m_resp_out);
    pop("t3");

    // Signed versus unsigned compares on mixed-sign lanes
    for (int i = 0; i < VL; i++) begin
      req_in1[i*LW +: LW] = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'd5;
      req_in2[i*LW +: LW] = 32'd1;
      exp_l[i] = (i % 2 == 1) ? 32'd1 : 32'd0;
    end
    send(OP_SLT, 1'b1, lat);
    chk("slt_lat", 32'(lat), 32'd9);
    chk_lanes("slt", m_resp_out);
    pop("slt");
    for (int i = 0; i < VL; i++) exp_l[i] = 32'd1;
    send(OP_SGEU, 1'b1, lat);
    chk_lanes("sgeu", m_resp_out);
    pop("sgeu");

    // SUB
    for (int i = 0; i < VL; i++) begin
      req_in1[i*LW +: LW] = 32'(i);
      req_in2[i*LW +: LW] = 32'hFFFF_FFFF;
      exp_l[i] = 32'(i + 1);
    end
    send(OP_SUB, 1'b1, lat);
    chk_lanes("sub", m_resp_out);
    pop("sub");

    // T6 undefined op code gives zero in every lane
    for (int i = 0; i < VL; i++) exp_l[i] = '0;
    send(OP_UNDEF, 1'b1, lat);
    chk("t6_lat", 32'(lat), 32'd9);
    chk_lanes("t6", m_resp_out);
    pop("t6");

    // T5 reset during beat 3 aborts the op
    load_add_vectors();
    req_op = OP_ADD; req_xvec_mode = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_busy_run", 32'(m_busy), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_req_ready", 32'(m_req_ready), 32'd1);
    chk("t5_resp_valid", 32'(m_resp_valid), 32'd0);
    chk("t5_busy", 32'(m_busy), 32'd0);
    for (int i = 0; i < VL; i++) exp_l[i] = '0;
    chk_lanes("t5_out", m_resp_out);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (m_resp_valid) seen = 1'b1;
    end
    chk("t5_no_resp", 32'(seen), 32'd0);
    load_add_vectors();
    send(OP_ADD, 1'b1, lat);
    chk("t5_after_lat", 32'(lat), 32'd9);
    chk_lanes("t5_after", m_resp_out);
    pop("t5_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
